egg_timer_sequencer: RTL and testbench

//  Central controller for the egg-timer datapath. Edge-detects the set/run keys and runs the

---
 rtl/egg_timer_pkg.sv | 23 ++
 rtl/egg_timer_sequencer_tick_prescaler.sv | 30 +++
 rtl/egg_timer_sequencer.sv | 150 +++++++++++++++
 tb/tb_egg_timer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer datapath: state encoding, default
// dividers and a counter-width helper used by the prescalers.
package egg_timer_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_SET_SEC = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_FLASH   = 3'd5
    } state_t;

    localparam int DEFAULT_TICK_DIV      = 50_000_000;
    localparam int DEFAULT_FLASH_DIV     = 12_500_000;
    localparam int DEFAULT_FLASH_TIMEOUT = 10;

    // A divider of 1 still needs a one-bit counter to elaborate cleanly.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/egg_timer_sequencer_tick_prescaler.sv
// tick_prescaler: counts enabled cycles 0..DIV-1 and flags the terminal
// count combinationally; clr restarts the count without producing a tick.
module tick_prescaler
    import egg_timer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             W    = cnt_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick = en & ~clr & (count_reg == LAST);

endmodule

// File: rtl/egg_timer_sequencer.sv
// Egg-timer control FSM: key edge detection, setting/run strobes, 1 Hz
// countdown pulses and alarm LED blink. Optional FLASH auto-timeout: EGG_FLASH_TIMEOUT_EN.
module egg_timer_sequencer
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int FLASH_DIV = DEFAULT_FLASH_DIV
`ifdef EGG_FLASH_TIMEOUT_EN
    ,
    parameter int FLASH_TIMEOUT = DEFAULT_FLASH_TIMEOUT
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_set,
    input  logic       key_run,
    input  logic       count_zero,
    output logic [2:0] state,
    output logic       load_sec,
    output logic       load_min,
    output logic       load_run,
    output logic       dec_pulse,
    output logic       led_flash
);

    state_t     state_reg, state_next;
    logic [1:0] key_lvl, key_q_reg, key_press;
    logic       set_press, run_press;
    logic       load_run_reg, load_run_next;
    logic       dec_pulse_reg, dec_pulse_next;
    logic       led_flash_reg, led_flash_next;
    logic       run_clr, run_en, run_tick;
    logic       flash_clr, flash_en, flash_tick;

    // Bit 0 = set key, bit 1 = run key; a held key produces one press only.
    assign key_lvl = {key_run, key_set};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key_edge
            assign key_press[gi] = key_lvl[gi] & ~key_q_reg[gi];
        end
    endgenerate

    assign set_press = key_press[0];
    assign run_press = key_press[1];

`ifdef EGG_FLASH_TIMEOUT_EN
    logic sec_tick, timeout_tick;

    tick_prescaler #(.DIV(TICK_DIV)) u_flash_sec (
        .clk   (clk),
        .reset (reset),
        .clr   (flash_clr),
        .en    (flash_en),
        .tick  (sec_tick)
    );

    tick_prescaler #(.DIV(FLASH_TIMEOUT)) u_flash_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (flash_clr),
        .en    (sec_tick),
        .tick  (timeout_tick)
    );
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:    if (set_press) state_next = ST_SET_SEC;
            ST_SET_SEC: if (set_press) state_next = ST_SET_MIN;
            ST_SET_MIN: begin
                if (set_press)      state_next = ST_SET_SEC;
                else if (run_press) state_next = ST_RUN;
            end
            ST_RUN: begin
                // Reaching zero beats a pause request; set is meaningless here.
                if (count_zero)     state_next = ST_FLASH;
                else if (run_press) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (set_press)      state_next = ST_SET_SEC;
                else if (run_press) state_next = ST_RUN;
            end
            ST_FLASH: begin
                if (set_press) state_next = ST_INIT;
`ifdef EGG_FLASH_TIMEOUT_EN
                else if (timeout_tick) state_next = ST_INIT;
`endif
            end
            default: state_next = ST_INIT;
        endcase
    end

    // The countdown prescaler only restarts on a fresh run from SET_MIN, so
    // PAUSE -> RUN resumes part-way through the current second.
    assign run_clr   = (state_reg == ST_SET_MIN) && (state_next == ST_RUN);
    assign run_en    = (state_reg == ST_RUN);
    assign flash_clr = (state_reg != ST_FLASH) && (state_next == ST_FLASH);
    assign flash_en  = (state_reg == ST_FLASH);

    tick_prescaler #(.DIV(TICK_DIV)) u_run_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .tick  (run_tick)
    );

    tick_prescaler #(.DIV(FLASH_DIV)) u_flash_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (flash_clr),
        .en    (flash_en),
        .tick  (flash_tick)
    );

    always_comb begin
        load_run_next  = run_clr;
        dec_pulse_next = run_tick && (state_next == ST_RUN);
        led_flash_next = 1'b0;
        if (state_next == ST_FLASH) begin
            led_flash_next = flash_clr ? 1'b1 : (led_flash_reg ^ flash_tick);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            key_q_reg     <= '0;
            load_run_reg  <= 1'b0;
            dec_pulse_reg <= 1'b0;
            led_flash_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_q_reg     <= key_lvl;
            load_run_reg  <= load_run_next;
            dec_pulse_reg <= dec_pulse_next;
            led_flash_reg <= led_flash_next;
        end
    end

    assign state     = state_reg;
    assign load_sec  = (state_reg == ST_SET_SEC);
    assign load_min  = (state_reg == ST_SET_MIN);
    assign load_run  = load_run_reg;
    assign dec_pulse = dec_pulse_reg;
    assign led_flash = led_flash_reg;

endmodule

// File: tb/tb_egg_timer_sequencer.sv
// Bench for egg_timer_sequencer with small dividers: directed scenarios plus
// randomized keys checked against a cycle-level behavioural model.
module tb_egg_timer_sequencer;

    localparam int TD = 4;
    localparam int FD = 2;
    localparam int FT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_set = 1'b0;
    logic       key_run = 1'b0;
    logic       count_zero = 1'b0;
    logic [2:0] state;
    logic       load_sec, load_min, load_run, dec_pulse, led_flash;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_state = 0;
    int m_sub   = 0;
    int m_fk    = 0;
    bit m_pset  = 0;
    bit m_prun  = 0;
    bit m_lr    = 0;
    bit m_dec   = 0;
    bit m_led   = 0;

    always #5 clk = ~clk;

    egg_timer_sequencer #(
        .TICK_DIV  (TD),
        .FLASH_DIV (FD)
`ifdef EGG_FLASH_TIMEOUT_EN
        ,
        .FLASH_TIMEOUT (FT)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_set    (key_set),
        .key_run    (key_run),
        .count_zero (count_zero),
        .state      (state),
        .load_sec   (load_sec),
        .load_min   (load_min),
        .load_run   (load_run),
        .dec_pulse  (dec_pulse),
        .led_flash  (led_flash)
    );

    // One clock of the timer as described by its rules: m_sub counts RUN
    // cycles elapsed in the current second, m_fk counts cycles spent in FLASH.
    task automatic model_step(input bit rst, input bit ks, input bit kr, input bit cz);
        bit sp, rp;
        int ns;
        if (rst) begin
            m_state = 0; m_sub = 0; m_fk = 0; m_pset = 0; m_prun = 0;
            m_lr = 0; m_dec = 0; m_led = 0;
            return;
        end
        sp = ks && !m_pset;
        rp = kr && !m_prun;
        m_pset = ks;
        m_prun = kr;
        ns = m_state;
        m_lr = 0;
        m_dec = 0;
        case (m_state)
            0: if (sp) ns = 1;
            1: if (sp) ns = 2;
            2: begin
                if (sp) ns = 1;
                else if (rp) begin ns = 3; m_lr = 1; m_sub = 0; end
            end
            3: begin
                if (cz) ns = 5;
                else if (rp) ns = 4;
                m_sub = m_sub + 1;
                if (m_sub == TD) begin
                    m_sub = 0;
                    m_dec = (ns == 3);
                end
            end
            4: begin
                if (sp) ns = 1;
                else if (rp) ns = 3;
            end
            5: begin
                if (sp) ns = 0;
`ifdef EGG_FLASH_TIMEOUT_EN
                else if (m_fk == TD * FT - 1) ns = 0;
`endif
            end
            default: ns = 0;
        endcase
        if (ns == 5) begin
            if (m_state != 5) m_fk = 0;
            else m_fk = m_fk + 1;
            m_led = ((m_fk / FD) % 2) == 0;
        end else begin
            m_led = 0;
        end
        m_state = ns;
    endtask

    // Drive one cycle's inputs, advance the clock and the model, sample at negedge.
    task automatic step(input bit rst, input bit ks, input bit kr, input bit cz);
        reset = rst; key_set = ks; key_run = kr; count_zero = cz;
        @(posedge clk);
        model_step(rst, ks, kr, cz);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        total += 6;
        if (state !== 3'd0)    begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        if (load_sec !== 1'b0) begin bad++; $display("FAIL reset_load_sec got=%b want=0", load_sec); end
        if (load_min !== 1'b0) begin bad++; $display("FAIL reset_load_min got=%b want=0", load_min); end
        if (load_run !== 1'b0) begin bad++; $display("FAIL reset_load_run got=%b want=0", load_run); end
        if (dec_pulse !== 1'b0) begin bad++; $display("FAIL reset_dec_pulse got=%b want=0", dec_pulse); end
        if (led_flash !== 1'b0) begin bad++; $display("FAIL reset_led_flash got=%b want=0", led_flash); end
        step(0, 0, 0, 0);
        $display("test_reset: state=%0d", state);
    endtask

    task automatic test_setup_and_run();
        int n_dec, n_lr;
        step(0, 1, 0, 0);
        total += 2;
        if (state !== 3'd1)    begin bad++; $display("FAIL setup_sec_state got=%0d want=1", state); end
        if (load_sec !== 1'b1) begin bad++; $display("FAIL setup_load_sec got=%b want=1", load_sec); end
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        total += 2;
        if (state !== 3'd2)    begin bad++; $display("FAIL setup_min_state got=%0d want=2", state); end
        if (load_min !== 1'b1) begin bad++; $display("FAIL setup_load_min got=%b want=1", load_min); end
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        total += 2;
        if (state !== 3'd3)    begin bad++; $display("FAIL setup_run_state got=%0d want=3", state); end
        if (load_run !== 1'b1) begin bad++; $display("FAIL setup_load_run got=%b want=1", load_run); end
        n_dec = 0;
        n_lr = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0);
            n_dec += int'(dec_pulse);
            n_lr  += int'(load_run);
            total++;
            if (dec_pulse !== m_dec) begin
                bad++; $display("FAIL run_dec_pulse cycle=%0d got=%b want=%b", i, dec_pulse, m_dec);
            end
        end
        total += 2;
        if (n_dec != 3) begin bad++; $display("FAIL run_dec_count got=%0d want=3", n_dec); end
        if (n_lr != 0)  begin bad++; $display("FAIL run_load_run_extra got=%0d want=0", n_lr); end
        $display("test_setup_and_run: dec_pulses=%0d", n_dec);
    endtask

    task automatic test_pause_resume();
        bit exp_dec [3];
        exp_dec = '{1'b0, 1'b0, 1'b1};
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            total += 2;
            if (state !== 3'd4)     begin bad++; $display("FAIL pause_state i=%0d got=%0d want=4", i, state); end
            if (dec_pulse !== 1'b0) begin bad++; $display("FAIL pause_dec i=%0d got=%b want=0", i, dec_pulse); end
            step(0, 0, 0, 0);
        end
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            total += 2;
            if (state !== 3'd3) begin bad++; $display("FAIL resume_state i=%0d got=%0d want=3", i, state); end
            if (dec_pulse !== exp_dec[i]) begin
                bad++; $display("FAIL resume_dec i=%0d got=%b want=%b", i, dec_pulse, exp_dec[i]);
            end
            if (i < 2) step(0, 0, 0, 0);
        end
        $display("test_pause_resume: state=%0d", state);
    endtask

    task automatic test_zero_beats_run();
        bit exp_led [5];
        exp_led = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        step(0, 0, 1, 1);
        total++;
        if (state !== 3'd5) begin bad++; $display("FAIL zero_priority_state got=%0d want=5", state); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (led_flash !== exp_led[i]) begin
                bad++; $display("FAIL flash_led i=%0d got=%b want=%b", i, led_flash, exp_led[i]);
            end
            if (i < 4) step(0, 0, 0, 0);
        end
        $display("test_zero_beats_run: state=%0d", state);
    endtask

    task automatic test_flash_hold();
        int n_exit;
        logic [2:0] prev;
        n_exit = 0;
        prev = state;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0);
            if (prev == 3'd5 && state == 3'd0) n_exit++;
            prev = state;
            total++;
            if (state !== 3'(m_state)) begin
                bad++; $display("FAIL hold_state i=%0d got=%0d want=%0d", i, state, m_state);
            end
        end
        total += 3;
        if (n_exit != 1)        begin bad++; $display("FAIL hold_exit_count got=%0d want=1", n_exit); end
        if (state !== 3'd0)     begin bad++; $display("FAIL hold_final_state got=%0d want=0", state); end
        if (led_flash !== 1'b0) begin bad++; $display("FAIL hold_led got=%b want=0", led_flash); end
        step(0, 0, 0, 0);
        $display("test_flash_hold: exits=%0d", n_exit);
    endtask

    task automatic test_flash_timeout();
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        total++;
        if (state !== 3'd5) begin bad++; $display("FAIL timeout_entry got=%0d want=5", state); end
`ifdef EGG_FLASH_TIMEOUT_EN
        for (int i = 1; i < TD * FT; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (state !== 3'd5) begin bad++; $display("FAIL timeout_early i=%0d got=%0d want=5", i, state); end
        end
        step(0, 0, 0, 0);
        total += 2;
        if (state !== 3'd0)     begin bad++; $display("FAIL timeout_exit got=%0d want=0", state); end
        if (led_flash !== 1'b0) begin bad++; $display("FAIL timeout_led got=%b want=0", led_flash); end
`else
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0);
            total += 2;
            if (state !== 3'd5) begin bad++; $display("FAIL flash_persist i=%0d got=%0d want=5", i, state); end
            if (led_flash !== m_led) begin
                bad++; $display("FAIL flash_persist_led i=%0d got=%b want=%b", i, led_flash, m_led);
            end
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
`endif
        $display("test_flash_timeout: state=%0d", state);
    endtask

    task automatic test_reset_at_terminal();
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        total++;
        if (state !== 3'd3) begin bad++; $display("FAIL term_pre_state got=%0d want=3", state); end
        step(1, 0, 0, 0);
        total += 3;
        if (state !== 3'd0)     begin bad++; $display("FAIL term_reset_state got=%0d want=0", state); end
        if (dec_pulse !== 1'b0) begin bad++; $display("FAIL term_reset_dec got=%b want=0", dec_pulse); end
        if (load_run !== 1'b0)  begin bad++; $display("FAIL term_reset_load_run got=%b want=0", load_run); end
        step(0, 0, 0, 0);
        $display("test_reset_at_terminal: state=%0d", state);
    endtask

    task automatic test_random();
        bit rst, ks, kr, cz;
        int errs_before;
        errs_before = bad;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            ks  = ($urandom_range(0, 5) == 0);
            kr  = ($urandom_range(0, 3) == 0);
            cz  = ($urandom_range(0, 19) == 0);
            step(rst, ks, kr, cz);
            total += 6;
            if (state !== 3'(m_state)) begin bad++; $display("FAIL rnd_state i=%0d got=%0d want=%0d", i, state, m_state); end
            if (load_sec !== (m_state == 1)) begin bad++; $display("FAIL rnd_load_sec i=%0d got=%b want=%b", i, load_sec, m_state == 1); end
            if (load_min !== (m_state == 2)) begin bad++; $display("FAIL rnd_load_min i=%0d got=%b want=%b", i, load_min, m_state == 2); end
            if (load_run !== m_lr)  begin bad++; $display("FAIL rnd_load_run i=%0d got=%b want=%b", i, load_run, m_lr); end
            if (dec_pulse !== m_dec) begin bad++; $display("FAIL rnd_dec_pulse i=%0d got=%b want=%b", i, dec_pulse, m_dec); end
            if (led_flash !== m_led) begin bad++; $display("FAIL rnd_led_flash i=%0d got=%b want=%b", i, led_flash, m_led); end
        end
        $display("test_random: cycles=3000 new_errors=%0d", bad - errs_before);
    endtask

    initial begin
        test_reset();
        test_setup_and_run();
        test_pause_resume();
        test_zero_beats_run();
        test_flash_hold();
        test_flash_timeout();
        test_reset_at_terminal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
